freq_div_prog: RTL and testbench

FREQ_DIV_PROG -- requirements
Module: freq_div_prog

---
 rtl/freq_div_prog_pkg.sv | 12 +
 rtl/freq_div_negcap.sv | 25 ++
 rtl/freq_div_prog.sv | 144 ++++++++++++++
 tb/tb_freq_div_prog.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_prog_pkg.sv
// Shared definitions for the programmable clock divider: FSM state
// encoding and the smallest divisor the block accepts.
package freq_div_prog_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/freq_div_negcap.sv
// Falling-edge capture flop used to stretch the high phase by half a clk
// for odd divisors.
//   clk : divider clock (captures on the falling edge)
//   rst : asynchronous active-high reset, clears the flop
//   d_i : posedge-domain level to capture
//   q_o : d_i delayed to the next falling edge
module freq_div_negcap
    import freq_div_prog_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/freq_div_prog.sv
// Programmable clock divider: clk_out = clk/N with a 50% duty cycle for
// even N and a half-clk-balanced duty for odd N. New divisors requested
// while running are held until the current period ends.
//   clk     : divider clock (both edges used)
//   rst     : asynchronous active-high reset
//   en      : run request, honoured at period boundaries
//   load    : one-cycle request to take div_in as the new divisor
//   div_in  : requested divisor (valid when >= 2)
//   clk_out : divided clock
//   tick    : one-clk pulse on the edge that starts each period
//   div_cur : divisor in effect
//   pend    : a loaded divisor is waiting for the period boundary
//   err     : one-clk pulse for a load with div_in < 2
module freq_div_prog
    import freq_div_prog_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned DEF_DIV = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] div_in,
    output logic         clk_out,
    output logic         tick,
    output logic [W-1:0] div_cur,
    output logic         pend,
    output logic         err
);

    state_e         state_q,    state_d;
    logic [W-1:0]   cnt_q,      cnt_d;
    logic           q_pos_q,    q_pos_d;
    logic           tick_q,     tick_d;
    logic           err_q,      err_d;
    logic [W-1:0]   div_cur_q,  div_cur_d;
    logic           pend_q,     pend_d;
    logic [W-1:0]   pend_div_q, pend_div_d;
    logic           q_neg;
    logic [W-1:0]   half_c;
    logic           load_ok_c;
    logic           wrap_c;

    // ceil(N/2) without needing a W+1 bit intermediate
    assign half_c    = (div_cur_q >> 1) + W'(div_cur_q[0]);
    assign load_ok_c = load && (div_in >= W'(MIN_DIV));
    assign wrap_c    = (cnt_q == div_cur_q - W'(1));

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_pos_d    = q_pos_q;
        tick_d     = 1'b0;
        err_d      = load && !load_ok_c;
        div_cur_d  = div_cur_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                q_pos_d = 1'b0;
                // Idle is a period boundary: a held divisor takes effect now,
                // and a fresh load overrides it directly.
                if (pend_q) begin
                    div_cur_d = pend_div_q;
                    pend_d    = 1'b0;
                end
                if (load_ok_c) begin
                    div_cur_d = div_in;
                    pend_d    = 1'b0;
                end
                // Start edge behaves as count 0 of a new period
                if (en) begin
                    state_d = ST_RUN;
                    cnt_d   = W'(1);
                    q_pos_d = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            ST_RUN: begin
                q_pos_d = (cnt_q < half_c);
                tick_d  = (cnt_q == '0);
                if (wrap_c) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        div_cur_d = pend_div_q;
                        pend_d    = 1'b0;
                    end
                    if (!en) state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
                // Applied after the boundary update so a load on the wrap
                // edge becomes the next pending value
                if (load_ok_c) begin
                    pend_div_d = div_in;
                    pend_d     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            q_pos_q    <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            div_cur_q  <= W'(DEF_DIV);
            pend_q     <= 1'b0;
            pend_div_q <= W'(DEF_DIV);
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            q_pos_q    <= q_pos_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            div_cur_q  <= div_cur_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
        end
    end

    freq_div_negcap u_negcap (
        .clk (clk),
        .rst (rst),
        .d_i (q_pos_q),
        .q_o (q_neg)
    );

    // Odd divisors AND in the half-clk delayed copy to balance the duty
    assign clk_out = div_cur_q[0] ? (q_pos_q & q_neg) : q_pos_q;
    assign tick    = tick_q;
    assign err     = err_q;
    assign div_cur = div_cur_q;
    assign pend    = pend_q;

endmodule

// File: tb/tb_freq_div_prog.sv
// Self-checking bench for freq_div_prog: a period/phase model predicts
// every output after each clk edge; directed scenarios add literal checks.
module tb_freq_div_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] div_in;
    logic       clk_out;
    logic       tick;
    logic [7:0] div_cur;
    logic       pend;
    logic       err;

    int n_vec;
    int n_err;

    // Model: m_in = inside a period, m_nph = phase the next edge will have,
    // m_lph/m_ln = phase and divisor of the most recent edge (-1 = none)
    bit m_in;
    int m_nph;
    int m_lph;
    int m_ln;
    int m_div;
    int m_pdiv;
    bit m_pend;
    bit m_tick;
    bit m_err;

    freq_div_prog #(.W(8), .DEF_DIV(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .clk_out (clk_out),
        .tick    (tick),
        .div_cur (div_cur),
        .pend    (pend),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_in   = 1'b0;
        m_nph  = 0;
        m_lph  = -1;
        m_ln   = 3;
        m_div  = 3;
        m_pdiv = 3;
        m_pend = 1'b0;
        m_tick = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit ld, input int din);
        bit ok;
        int p;
        ok     = ld && (din >= 2);
        m_err  = ld && (din < 2);
        m_tick = 1'b0;
        if (!m_in) begin
            if (m_pend) begin m_div = m_pdiv; m_pend = 1'b0; end
            if (ok)     begin m_div = din;    m_pend = 1'b0; end
            if (e) begin
                m_in = 1'b1; m_lph = 0; m_ln = m_div; m_tick = 1'b1; m_nph = 1;
            end else begin
                m_lph = -1;
            end
        end else begin
            p      = m_nph;
            m_lph  = p;
            m_ln   = m_div;
            m_tick = (p == 0);
            if (p == m_div - 1) begin
                if (m_pend) begin m_div = m_pdiv; m_pend = 1'b0; end
                if (ok)     begin m_pdiv = din;   m_pend = 1'b1; end
                if (e) m_nph = 0;
                else   m_in  = 1'b0;
            end else begin
                if (ok) begin m_pdiv = din; m_pend = 1'b1; end
                m_nph = p + 1;
            end
        end
    endtask

    // clk_out in the first half of the clk cycle after an edge of phase p
    function automatic bit exp_pos();
        if (m_lph < 0) return 1'b0;
        if (m_ln % 2 == 0) return m_lph < m_ln / 2;
        return (m_lph >= 1) && (m_lph < (m_ln + 1) / 2);
    endfunction

    // clk_out in the second half of that cycle
    function automatic bit exp_neg();
        if (m_lph < 0) return 1'b0;
        return m_lph < (m_ln + 1) / 2;
    endfunction

    // Compare process: posedge-domain outputs and the first half of clk_out
    always @(posedge clk) begin
        if (!rst) model_edge(en, load, int'(div_in));
        #1;
        chk("tick",      32'(tick),    32'(m_tick));
        chk("err",       32'(err),     32'(m_err));
        chk("pend",      32'(pend),    32'(m_pend));
        chk("div_cur",   32'(div_cur), 32'(m_div));
        chk("clk_out_p", 32'(clk_out), 32'(exp_pos()));
    end

    always @(negedge clk) begin
        #1;
        chk("clk_out_n", 32'(clk_out), 32'(exp_neg()));
    end

    task automatic cyc(input bit e, input bit l, input int d);
        @(negedge clk);
        en = e; load = l; div_in = 8'(d);
        @(posedge clk);
        #2;
    endtask

    task automatic measure(input int n, output int ticks, output int highs);
        ticks = 0;
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ticks += int'(tick);
            highs += int'(clk_out);
            @(negedge clk); #1;
            highs += int'(clk_out);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (m_in && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (m_in) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: got running expected idle within 300 cycles");
        end
    endtask

    task automatic wait_nph(input int p);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m_in && m_nph == p) && k < 64);
        if (!(m_in && m_nph == p)) begin
            n_vec++; n_err++;
            $display("FAIL wait_phase: got phase %0d expected %0d within 64 cycles", m_nph, p);
        end
    endtask

    initial begin
        int t;
        int h;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; en = 1'b0; load = 1'b0; div_in = 8'd0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_div_cur", 32'(div_cur), 32'd3);
        chk("rst_pend",    32'(pend),    32'd0);
        #3 rst = 1'b0;
        repeat (3) cyc(0, 0, 0);

        // Default divisor 3: tick every 3rd edge, 1.5 clk high per period
        @(negedge clk); en = 1'b1;
        measure(9, t, h);
        chk("n3_ticks", 32'(t), 32'd3);
        chk("n3_highs", 32'(h), 32'd9);
        @(negedge clk); en = 1'b0;
        wait_idle();

        // Load 8 while idle: 4 high / 4 low
        cyc(0, 1, 8);
        cyc(0, 0, 0);
        chk("n8_div_cur", 32'(div_cur), 32'd8);
        @(negedge clk); en = 1'b1;
        measure(16, t, h);
        chk("n8_ticks", 32'(t), 32'd2);
        chk("n8_highs", 32'(h), 32'd16);
        @(negedge clk); en = 1'b0;
        wait_idle();

        // N=5 running, load 4 at count 1: applied at the boundary
        cyc(0, 1, 5);
        @(negedge clk); en = 1'b1; load = 1'b0;
        @(negedge clk); load = 1'b1; div_in = 8'd4;
        @(posedge clk); #2;
        chk("n5_pend_set", 32'(pend),    32'd1);
        chk("n5_div_keep", 32'(div_cur), 32'd5);
        @(negedge clk); load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("n4_pend_clr", 32'(pend),    32'd0);
        chk("n4_div_cur",  32'(div_cur), 32'd4);
        measure(8, t, h);
        chk("n4_ticks", 32'(t), 32'd2);
        chk("n4_highs", 32'(h), 32'd8);

        // Last load wins; a load on the wrap edge becomes the next pending
        wait_nph(1);
        load = 1'b1; div_in = 8'd6;
        @(negedge clk); div_in = 8'd7;
        @(negedge clk); div_in = 8'd2;
        @(posedge clk); #2;
        chk("lw_div_cur", 32'(div_cur), 32'd7);
        chk("lw_pend",    32'(pend),    32'd1);
        @(negedge clk); load = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("lw2_div_cur", 32'(div_cur), 32'd2);
        chk("lw2_pend",    32'(pend),    32'd0);

        // Invalid divisors flag err and change nothing
        cyc(1, 1, 1);
        chk("err1",       32'(err),     32'd1);
        chk("err1_div",   32'(div_cur), 32'd2);
        cyc(1, 1, 0);
        chk("err0",       32'(err),     32'd1);
        chk("err0_pend",  32'(pend),    32'd0);
        cyc(1, 0, 0);
        chk("err_clear",  32'(err),     32'd0);

        // en dropped at count 2 of N=7: period completes then stays low
        @(negedge clk); en = 1'b0;
        wait_idle();
        cyc(0, 1, 7);
        @(negedge clk); en = 1'b1; load = 1'b0;
        wait_nph(2);
        en = 1'b0;
        measure(12, t, h);
        chk("stop_ticks", 32'(t), 32'd0);
        chk("stop_highs", 32'(h), 32'd4);

        // Reset during the high phase drops clk_out at once
        @(negedge clk); en = 1'b1;
        wait_nph(1);
        load = 1'b1; div_in = 8'd5;
        @(negedge clk); load = 1'b0;
        #3;
        chk("pre_rst_high", 32'(clk_out), 32'd1);
        chk("pre_rst_pend", 32'(pend),    32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_clk_out", 32'(clk_out), 32'd0);
        chk("mid_rst_div_cur", 32'(div_cur), 32'd3);
        chk("mid_rst_pend",    32'(pend),    32'd0);
        @(negedge clk); #3 rst = 1'b0; en = 1'b0;
        repeat (3) cyc(0, 0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en     = ($urandom_range(0, 7) != 0);
            load   = ($urandom_range(0, 5) == 0);
            div_in = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 399) == 0) begin
                #3 rst = 1'b1;
                model_reset();
                @(negedge clk);
                #3 rst = 1'b0;
            end
        end
        @(negedge clk); en = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
